regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port register file; next generation of the 32-entry, 32-bit, single-read register file.
- Generalised in data width, depth and read-port count.
- Adds an optional registered read stage, write-to-read bypass, a hardwired-zero register 0, and a per-register pending (scoreboard) bit.
- Sits between the decode stage, which issues reads and marks destinations pending, and the writeback stage, which writes and clears pending.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 32, number of registers; must be a power of 2 and at least 2.
- AW, 5, address width; must equal log2(DEPTH).
- NRD, 2, number of read ports, 1..4.
- REG_OUT, 0. 0: combinational read. 1: read data registered, 1-cycle latency.
- BYPASS, 1. 1: a same-cycle write is forwarded to matching read ports.
- R0_ZERO, 1. 1: register 0 always reads 0 and is never written or marked pending.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*DW  read data; port i uses bits [i*DW +: DW].
- rbusy  out  NRD  pending bit of the register addressed by port i.
- pset  in  1  mark register pset_addr pending.
- pset_addr  in  AW  register to mark pending.
- pend_all  out  DEPTH  full pending vector, bit n for register n.

Behaviour:
- Reset, taking effect on the clk edge with rst=1:
  - all registers cleared to 0 and all pending bits cleared;
  - with REG_OUT=1, rdata and rbusy are cleared to 0;
  - rst overrides we and pset in the same cycle.
  - With REG_OUT=0, outputs follow the cleared state combinationally from the next cycle.
- Write: on a clk edge with we=1, reg[waddr] <= wdata. With R0_ZERO=1 and waddr=0 the write is dropped.
- Pending set: on a clk edge with pset=1, pend[pset_addr] <= 1. Ignored for address 0 when R0_ZERO=1.
- Pending clear: a write with we=1 clears pend[waddr] on the same edge.
- pset and we to the same address in the same cycle: the register is written AND pend stays 1 (set wins; a new producer was issued). pset and we to different addresses act independently.
- Read value per port i, with a = raddr[i]:
  - if R0_ZERO=1 and a=0, the value is 0;
  - else if BYPASS=1, we=1 and waddr=a, the value is wdata;
  - else the value is reg[a].
- Read busy per port i:
  - with BYPASS=1 and a matching same-cycle write (and no same-address pset), the busy value is 0;
  - otherwise it is pend[a];
  - always 0 for address 0 when R0_ZERO=1.
- REG_OUT=0: rdata and rbusy are combinational from raddr, state and (if bypassing) we/waddr/wdata. Zero latency.
- REG_OUT=1: the value computed above is sampled into output registers at the clk edge; rdata and rbusy are valid one cycle after raddr is presented. Bypass applies to the write present in the sampling cycle.
- BYPASS=0: a read of an address written in the same cycle returns the old content; with REG_OUT=0 the new value appears the next cycle.
- All read ports are independent. Any number of ports may address the same register with identical results.
- pend_all reflects the state registers directly, with no bypass.
- Write data is stored exactly DW bits wide. No sign or width conversion.
- Addresses are all in range because DEPTH = 2^AW; no out-of-range handling is required.

Test Plan:
- Reset, then read all addresses on every port -> all rdata 0, rbusy 0, pend_all 0; with REG_OUT=1 the outputs are 0 from the first post-reset edge.
- Write 0xDEADBEEF to reg 7, next cycle raddr0=7, raddr1=7:
  - with REG_OUT=0, both ports return 0xDEADBEEF the same cycle;
  - with REG_OUT=1, both return it one cycle after raddr is applied.
- Same-cycle write 0x12345678 to reg 3 with raddr0=3:
  - with BYPASS=1, rdata0=0x12345678 in that cycle (REG_OUT=0);
  - with BYPASS=0, rdata0 holds the old value and 0x12345678 appears the next cycle.
- R0 check: write 0xFFFFFFFF to reg 0 and pset reg 0 -> rdata for raddr=0 stays 0, rbusy 0, pend_all[0]=0. Repeat with R0_ZERO=0 -> 0xFFFFFFFF is read and pend_all[0]=1.
- Scoreboard sequence on reg 9:
  - pset reg 9, then read reg 9 -> rbusy=1, pend_all[9]=1;
  - we reg 9=0xA5 -> pend cleared; rbusy=0 in the write cycle with BYPASS=1, or the next cycle with BYPASS=0;
  - simultaneous pset and we to reg 9 -> value 0xA5 stored and pend_all[9] remains 1.
- Mid-operation reset: fill regs 1..31 with their own index and pset regs 4 and 5, then assert rst one cycle with we=1 and pset=1 -> all regs read 0, pend_all 0; the write and pset in the reset cycle are discarded.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with optional registered
// read stage, write-to-read bypass, hardwired-zero register 0 and a
// per-register pending (scoreboard) bit set by decode and cleared by writeback.
module regfile_mp #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter int REG_OUT = 0,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              pset,
  input  logic [AW-1:0]     pset_addr,
  output logic [DEPTH-1:0]  pend_all
);

  logic [DW-1:0]     mem_r [DEPTH];
  logic [DEPTH-1:0]  pend_r;
  logic              wr_en_s;
  logic              pset_en_s;
  logic [NRD*DW-1:0] rd_data_s;
  logic [NRD-1:0]    rd_busy_s;

  // Drop writes and pending-sets aimed at register 0 when it is hardwired to zero
  always_comb begin
    wr_en_s   = we;
    pset_en_s = pset;
    if ((R0_ZERO != 0) && (waddr == {AW{1'b0}})) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = we;
    end
    if ((R0_ZERO != 0) && (pset_addr == {AW{1'b0}})) begin
      pset_en_s = 1'b0;
    end else begin
      pset_en_s = pset;
    end
  end

  // Register array: cleared on reset, otherwise one write per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < DEPTH; n++) begin
        mem_r[n] <= {DW{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Pending bits: a new producer (pset) wins over writeback clearing the same register
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      for (int n = 0; n < DEPTH; n++) begin
        if (pset_en_s && (pset_addr == AW'(n))) begin
          pend_r[n] <= 1'b1;
        end else if (wr_en_s && (waddr == AW'(n))) begin
          pend_r[n] <= 1'b0;
        end
      end
    end
  end

  // Per-port read value and busy flag, with zero register and same-cycle forwarding
  always_comb begin
    rd_data_s = {(NRD*DW){1'b0}};
    rd_busy_s = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      if ((R0_ZERO != 0) && (raddr[i*AW +: AW] == {AW{1'b0}})) begin
        rd_data_s[i*DW +: DW] = {DW{1'b0}};
        rd_busy_s[i]          = 1'b0;
      end else if ((BYPASS != 0) && we && (waddr == raddr[i*AW +: AW])) begin
        rd_data_s[i*DW +: DW] = wdata;
        // A same-address pset re-issues the producer, so the forwarded value is not final
        if (pset && (pset_addr == raddr[i*AW +: AW])) begin
          rd_busy_s[i] = pend_r[raddr[i*AW +: AW]];
        end else begin
          rd_busy_s[i] = 1'b0;
        end
      end else begin
        rd_data_s[i*DW +: DW] = mem_r[raddr[i*AW +: AW]];
        rd_busy_s[i]          = pend_r[raddr[i*AW +: AW]];
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg_out
    // Registered read stage: one cycle of latency from raddr to rdata/rbusy
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata <= {(NRD*DW){1'b0}};
        rbusy <= {NRD{1'b0}};
      end else begin
        rdata <= rd_data_s;
        rbusy <= rd_busy_s;
      end
    end
  end else begin : g_comb_out
    assign rdata = rd_data_s;
    assign rbusy = rd_busy_s;
  end

  assign pend_all = pend_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances share stimulus.
//   dut_a: combinational read, bypass on, register 0 hardwired to zero.
//   dut_b: registered read, bypass off, register 0 ordinary.
// A behavioural model of each configuration predicts every output.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic        pset;
  logic [4:0]  waddr;
  logic [4:0]  pset_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a;
  logic [63:0] rdata_b;
  logic [1:0]  rbusy_a;
  logic [1:0]  rbusy_b;
  logic [31:0] pend_a;
  logic [31:0] pend_b;

  int checks = 0;
  int errors = 0;

  // Reference state for each configuration
  logic [31:0] ma [32];
  logic [31:0] mb [32];
  logic [31:0] pa;
  logic [31:0] pb;
  logic [63:0] expb_rd;
  logic [1:0]  expb_bz;

  typedef struct {
    bit          r;
    bit          w;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          p;
    logic [4:0]  pad;
    logic [9:0]  ra;
  } step_t;

  always #5 clk = ~clk;

  regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .REG_OUT(0), .BYPASS(1), .R0_ZERO(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_a), .rbusy(rbusy_a), .pset(pset), .pset_addr(pset_addr), .pend_all(pend_a)
  );

  regfile_mp #(.DW(32), .DEPTH(32), .AW(5), .NRD(2), .REG_OUT(1), .BYPASS(0), .R0_ZERO(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rbusy(rbusy_b), .pset(pset), .pset_addr(pset_addr), .pend_all(pend_b)
  );

  function automatic step_t mk(input bit r, input bit w, input logic [4:0] wa, input logic [31:0] wd,
                               input bit p, input logic [4:0] pad, input logic [9:0] ra);
    step_t s;
    s.r = r; s.w = w; s.wa = wa; s.wd = wd; s.p = p; s.pad = pad; s.ra = ra;
    return s;
  endfunction

  task automatic apply(input step_t s);
    rst = s.r; we = s.w; waddr = s.wa; wdata = s.wd;
    pset = s.p; pset_addr = s.pad; raddr = s.ra;
  endtask

  // Read value seen by the read logic for the current inputs (isb selects configuration b)
  function automatic logic [63:0] exp_rd(input bit isb);
    logic [63:0] v;
    logic [4:0]  a;
    v = 64'd0;
    for (int p = 0; p < 2; p++) begin
      a = raddr[p*5 +: 5];
      if (!isb && a == 5'd0) v[p*32 +: 32] = 32'd0;
      else if (!isb && we && waddr == a) v[p*32 +: 32] = wdata;
      else v[p*32 +: 32] = isb ? mb[a] : ma[a];
    end
    return v;
  endfunction

  function automatic logic [1:0] exp_bz(input bit isb);
    logic [1:0] v;
    logic [4:0] a;
    v = 2'd0;
    for (int p = 0; p < 2; p++) begin
      a = raddr[p*5 +: 5];
      if (!isb && a == 5'd0) v[p] = 1'b0;
      else if (!isb && we && waddr == a && !(pset && pset_addr == a)) v[p] = 1'b0;
      else v[p] = isb ? pb[a] : pa[a];
    end
    return v;
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        ma[i] = 32'd0;
        mb[i] = 32'd0;
      end
      pa = 32'd0;
      pb = 32'd0;
    end else begin
      if (we) begin
        if (waddr != 5'd0) begin
          ma[waddr] = wdata;
          pa[waddr] = 1'b0;
        end
        mb[waddr] = wdata;
        pb[waddr] = 1'b0;
      end
      if (pset) begin
        if (pset_addr != 5'd0) pa[pset_addr] = 1'b1;
        pb[pset_addr] = 1'b1;
      end
    end
  endtask

  // Capture what dut_b should register, advance one clock, update the models
  task automatic tick();
    expb_rd = rst ? 64'd0 : exp_rd(1'b1);
    expb_bz = rst ? 2'd0 : exp_bz(1'b1);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    apply(mk(1'b1, 1'b1, 5'd5, $urandom, 1'b1, 5'd6, 10'd0));
    tick();
    checks++;
    if ({rdata_b, rbusy_b, pend_b, pend_a} !== 130'd0) begin
      errors++;
      $display("FAIL reset_first_edge got %h required 0", {rdata_b, rbusy_b, pend_b, pend_a});
    end
    for (int a = 0; a < 32; a++) begin
      apply(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'(a), 5'(31 - a)}));
      #1;
      checks++;
      if ({rdata_a, rbusy_a, pend_a} !== {exp_rd(1'b0), exp_bz(1'b0), pa}) begin
        errors++;
        $display("FAIL reset_a addr %0d got %h required %h", a, {rdata_a, rbusy_a, pend_a}, {exp_rd(1'b0), exp_bz(1'b0), pa});
      end
      tick();
      checks++;
      if ({rdata_b, rbusy_b, pend_b} !== {expb_rd, expb_bz, pb}) begin
        errors++;
        $display("FAIL reset_b addr %0d got %h required %h", a, {rdata_b, rbusy_b, pend_b}, {expb_rd, expb_bz, pb});
      end
    end
  endtask

  task automatic test_write_read();
    apply(mk(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, {5'd1, 5'd2}));
    tick();
    apply(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd7, 5'd7}));
    #1;
    checks++;
    if (rdata_a !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL write_read_a got %h required %h", rdata_a, {32'hDEADBEEF, 32'hDEADBEEF});
    end
    tick();
    checks++;
    if (rdata_b !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL write_read_b got %h required %h", rdata_b, {32'hDEADBEEF, 32'hDEADBEEF});
    end
  endtask

  task automatic test_bypass();
    step_t q[$];
    q.push_back(mk(1'b0, 1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, {5'd7, 5'd3}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd7, 5'd3}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd3, 5'd7}));
    foreach (q[k]) begin
      apply(q[k]);
      #1;
      checks++;
      if ({rdata_a, rbusy_a, pend_a} !== {exp_rd(1'b0), exp_bz(1'b0), pa}) begin
        errors++;
        $display("FAIL bypass_a step %0d got %h required %h", k, {rdata_a, rbusy_a, pend_a}, {exp_rd(1'b0), exp_bz(1'b0), pa});
      end
      if (k == 0) begin
        checks++;
        if (rdata_a[31:0] !== 32'h12345678) begin
          errors++;
          $display("FAIL bypass_forward got %h required %h", rdata_a[31:0], 32'h12345678);
        end
      end
      tick();
      checks++;
      if ({rdata_b, rbusy_b, pend_b} !== {expb_rd, expb_bz, pb}) begin
        errors++;
        $display("FAIL bypass_b step %0d got %h required %h", k, {rdata_b, rbusy_b, pend_b}, {expb_rd, expb_bz, pb});
      end
    end
  endtask

  task automatic test_r0();
    step_t q[$];
    q.push_back(mk(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, {5'd0, 5'd0}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd0, 5'd0}));
    foreach (q[k]) begin
      apply(q[k]);
      #1;
      checks++;
      if ({rdata_a, rbusy_a, pend_a} !== {exp_rd(1'b0), exp_bz(1'b0), pa}) begin
        errors++;
        $display("FAIL r0_a step %0d got %h required %h", k, {rdata_a, rbusy_a, pend_a}, {exp_rd(1'b0), exp_bz(1'b0), pa});
      end
      tick();
      checks++;
      if ({rdata_b, rbusy_b, pend_b} !== {expb_rd, expb_bz, pb}) begin
        errors++;
        $display("FAIL r0_b step %0d got %h required %h", k, {rdata_b, rbusy_b, pend_b}, {expb_rd, expb_bz, pb});
      end
    end
    checks++;
    if ({rdata_a[31:0], rbusy_a[0], pend_a[0], rdata_b[31:0], pend_b[0]} !== {32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1}) begin
      errors++;
      $display("FAIL r0_explicit got %h required %h", {rdata_a[31:0], rbusy_a[0], pend_a[0], rdata_b[31:0], pend_b[0]},
               {32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1});
    end
  endtask

  task automatic test_scoreboard();
    step_t q[$];
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, {5'd9, 5'd9}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd9, 5'd9}));
    q.push_back(mk(1'b0, 1'b1, 5'd9, 32'hA5, 1'b0, 5'd0, {5'd9, 5'd9}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd9, 5'd9}));
    q.push_back(mk(1'b0, 1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, {5'd9, 5'd9}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'd9, 5'd9}));
    foreach (q[k]) begin
      apply(q[k]);
      #1;
      checks++;
      if ({rdata_a, rbusy_a, pend_a} !== {exp_rd(1'b0), exp_bz(1'b0), pa}) begin
        errors++;
        $display("FAIL score_a step %0d got %h required %h", k, {rdata_a, rbusy_a, pend_a}, {exp_rd(1'b0), exp_bz(1'b0), pa});
      end
      tick();
      checks++;
      if ({rdata_b, rbusy_b, pend_b} !== {expb_rd, expb_bz, pb}) begin
        errors++;
        $display("FAIL score_b step %0d got %h required %h", k, {rdata_b, rbusy_b, pend_b}, {expb_rd, expb_bz, pb});
      end
    end
    checks++;
    if ({rdata_a[31:0], rbusy_a, pend_a[9], rdata_b[31:0], pend_b[9]} !== {32'hA5, 2'b11, 1'b1, 32'hA5, 1'b1}) begin
      errors++;
      $display("FAIL score_explicit got %h required %h", {rdata_a[31:0], rbusy_a, pend_a[9], rdata_b[31:0], pend_b[9]},
               {32'hA5, 2'b11, 1'b1, 32'hA5, 1'b1});
    end
  endtask

  task automatic test_mid_reset();
    step_t q[$];
    for (int i = 1; i < 32; i++) begin
      q.push_back(mk(1'b0, 1'b1, 5'(i), 32'(i), 1'b0, 5'd0, {5'(i), 5'(i - 1)}));
    end
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, {5'd4, 5'd5}));
    q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, {5'd4, 5'd5}));
    q.push_back(mk(1'b1, 1'b1, 5'd6, 32'hCAFEF00D, 1'b1, 5'd7, {5'd4, 5'd5}));
    for (int i = 0; i < 32; i++) begin
      q.push_back(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, {5'(i), 5'(31 - i)}));
    end
    foreach (q[k]) begin
      apply(q[k]);
      #1;
      checks++;
      if ({rdata_a, rbusy_a, pend_a} !== {exp_rd(1'b0), exp_bz(1'b0), pa}) begin
        errors++;
        $display("FAIL midrst_a step %0d got %h required %h", k, {rdata_a, rbusy_a, pend_a}, {exp_rd(1'b0), exp_bz(1'b0), pa});
      end
      tick();
      checks++;
      if ({rdata_b, rbusy_b, pend_b} !== {expb_rd, expb_bz, pb}) begin
        errors++;
        $display("FAIL midrst_b step %0d got %h required %h", k, {rdata_b, rbusy_b, pend_b}, {expb_rd, expb_bz, pb});
      end
      if (q[k].r) begin
        checks++;
        if ({pend_a, pend_b, rdata_b} !== 128'd0) begin
          errors++;
          $display("FAIL midrst_clear got %h required 0", {pend_a, pend_b, rdata_b});
        end
      end
    end
  endtask

  task automatic test_random();
    step_t s;
    for (int k = 0; k < 400; k++) begin
      s.r   = ($urandom_range(0, 49) == 0);
      s.w   = $urandom_range(0, 1);
      s.wa  = 5'($urandom_range(0, 7));
      s.wd  = $urandom;
      s.p   = ($urandom_range(0, 2) == 0);
      s.pad = ($urandom_range(0, 1) == 0) ? s.wa : 5'($urandom_range(0, 7));
      s.ra  = {($urandom_range(0, 1) == 0) ? s.wa : 5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      apply(s);
      #1;
      checks++;
      if ({rdata_a, rbusy_a, pend_a} !== {exp_rd(1'b0), exp_bz(1'b0), pa}) begin
        errors++;
        $display("FAIL random_a cycle %0d got %h required %h", k, {rdata_a, rbusy_a, pend_a}, {exp_rd(1'b0), exp_bz(1'b0), pa});
      end
      tick();
      checks++;
      if ({rdata_b, rbusy_b, pend_b} !== {expb_rd, expb_bz, pb}) begin
        errors++;
        $display("FAIL random_b cycle %0d got %h required %h", k, {rdata_b, rbusy_b, pend_b}, {expb_rd, expb_bz, pb});
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ma[i] = 32'd0;
      mb[i] = 32'd0;
    end
    pa = 32'd0;
    pb = 32'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
